// File: rtl/z16_pkg.sv
// Shared Z16 fetch-path definitions: widths, PC step, fetch FSM states and
// the buffered {pc, instr} entry layout.
package z16_pkg;

  localparam int unsigned Z16_INSTR_W = 16;
  localparam int unsigned Z16_ADDR_W  = 16;
  localparam logic [Z16_ADDR_W-1:0] Z16_PC_STEP = 16'd2;
  localparam int unsigned Z16_ENTRY_W = Z16_ADDR_W + Z16_INSTR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [Z16_ADDR_W-1:0]  pc;
    logic [Z16_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [Z16_ADDR_W-1:0] align_pc(input logic [Z16_ADDR_W-1:0] pc);
    return pc & ~Z16_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Synchronous fetch buffer with flush. Push and pop in the same cycle are
// both honoured even when full; flush empties it and ignores push/pop.
module z16_fetch_fifo
  import z16_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Z16_ENTRY_W-1:0] wdata,
  output logic [Z16_ENTRY_W-1:0] rdata,
  output logic                   valid,
  output logic                   full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign rdata = mem[rptr];

  always_comb begin
    do_pop  = pop & valid;
    do_push = push & (~full | do_pop);
  end

  // DEPTH is a power of two, so the pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/z16_fetch_ctrl.sv
// Z16 instruction-fetch controller: owns the fetch PC, sequences
// start/halt/redirect and feeds {pc, instr} pairs to decode via a buffer.
module z16_fetch_ctrl
  import z16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_halt,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_running,
  output logic        o_halted
);

  localparam logic [15:0] START_PC = align_pc(RESET_PC);

  fetch_state_t state;
  logic [15:0]  fpc;
  logic         pop;
  logic         push;
  logic         full;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign o_imem_addr = fpc;
  assign pop         = o_valid & i_ready;
  assign push        = (state == RUN) & ~i_halt & ~i_redirect & (~full | pop);
  assign wentry      = '{pc: fpc, instr: i_imem_instr};
  assign o_pc        = head.pc;
  assign o_instr     = head.instr;

  z16_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .valid (o_valid),
    .full  (full)
  );

  // Redirect only lets halt change the state; a start in the same cycle is ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      fpc       <= START_PC;
      o_running <= 1'b0;
      o_halted  <= 1'b0;
    end else if (i_redirect) begin
      fpc <= align_pc(i_redirect_pc);
      if (state == RUN && i_halt) begin
        state     <= HALT;
        o_running <= 1'b0;
        o_halted  <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_start && !i_halt) begin
            state     <= RUN;
            fpc       <= START_PC;
            o_running <= 1'b1;
          end
        end
        RUN: begin
          if (i_halt) begin
            state     <= HALT;
            o_running <= 1'b0;
            o_halted  <= 1'b1;
          end else if (push) begin
            fpc <= fpc + Z16_PC_STEP;
          end
        end
        HALT: begin
          if (i_start && !i_halt) begin
            state     <= RUN;
            o_running <= 1'b1;
            o_halted  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_running <= 1'b0;
          o_halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z16_fetch_ctrl.sv
// Scoreboard bench for z16_fetch_ctrl: the model predicts the sequential
// instruction stream decode should see; a monitor pops and compares it.
module tb_z16_fetch_ctrl;

  typedef enum int {M_IDLE, M_RUN, M_HALT} mstate_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_halt = 1'b0;
  logic [15:0] o_imem_addr;
  logic [15:0] i_imem_instr;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        i_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [15:0] i_redirect_pc = '0;
  logic        o_running;
  logic        o_halted;

  logic [15:0] mem [32768];
  int          tests = 0;
  int          fails = 0;

  mstate_t     mstate = M_IDLE;
  logic [31:0] exp_q[$];
  logic [15:0] tail_pc = '0;
  bit          armed = 0;

  always #5 clk = ~clk;

  assign i_imem_instr = mem[o_imem_addr[15:1]];

  z16_fetch_ctrl #(
    .RESET_PC (16'h0000),
    .DEPTH    (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_halt        (i_halt),
    .o_imem_addr   (o_imem_addr),
    .i_imem_instr  (i_imem_instr),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_running     (o_running),
    .o_halted      (o_halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The stream decode sees is simply consecutive halfword addresses from the
  // last start-from-idle or redirect target, each paired with its memory word.
  task automatic refill(input logic [15:0] pc);
    exp_q.delete();
    tail_pc = pc;
    armed   = 1;
  endtask

  task automatic topup();
    while (armed && exp_q.size() < 8) begin
      exp_q.push_back({tail_pc, mem[tail_pc[15:1]]});
      tail_pc = tail_pc + 16'd2;
    end
  endtask

  task automatic cycle(input logic st, input logic hl, input logic rd, input logic rdr,
                       input logic [15:0] rpc, input logic rs);
    i_start       = st;
    i_halt        = hl;
    i_ready       = rd;
    i_redirect    = rdr;
    i_redirect_pc = rpc;
    i_rst         = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      mstate = M_IDLE;
      exp_q.delete();
      armed = 0;
    end else if (rdr) begin
      refill({rpc[15:1], 1'b0});
      if (mstate == M_RUN && hl) mstate = M_HALT;
    end else begin
      case (mstate)
        M_IDLE: if (st && !hl) begin mstate = M_RUN; refill(16'h0000); end
        M_RUN:  if (hl) mstate = M_HALT;
        M_HALT: if (st && !hl) mstate = M_RUN;
        default: mstate = M_IDLE;
      endcase
    end
    topup();
    check("running", 32'(o_running), 32'(mstate == M_RUN));
    check("halted", 32'(o_halted), 32'(mstate == M_HALT));
    check("addr_even", 32'(o_imem_addr[0]), 32'd0);
  endtask

  // Monitor: every accepted head must be the next predicted entry, and a
  // stalled head must not change until accepted or flushed.
  initial begin : monitor
    bit          hold_prev;
    logic [31:0] held;
    logic [31:0] exp;
    hold_prev = 0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 32'(o_valid), 32'd1);
          check("hold_head", {o_pc, o_instr}, held);
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stream_extra: got %h expected no output", {o_pc, o_instr});
          end else begin
            exp = exp_q.pop_front();
            check("stream", {o_pc, o_instr}, exp);
          end
        end
        hold_prev = o_valid && !i_ready && !i_redirect;
        held      = {o_pc, o_instr};
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0040;
    mem[1] = 16'h605D;
    mem[2] = 16'h0000;
    mem[3] = 16'h0000;
    mem[4] = 16'h006C;

    cycle(0, 0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 0, 16'h0, 1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_instr", 32'(o_instr), 32'd0);
    check("rst_pc", 32'(o_pc), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'h0000);

    // Basic stream with ready held high.
    cycle(1, 0, 1, 0, 16'h0, 0);
    check("start_running", 32'(o_running), 32'd1);
    check("start_novalid", 32'(o_valid), 32'd0);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("s2_head", {15'd0, o_valid, o_pc, o_instr}, {15'd0, 1'b1, 16'h0000, 16'h0040});
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("s3_head", {15'd0, o_valid, o_pc, o_instr}, {15'd0, 1'b1, 16'h0002, 16'h605D});
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("s4_head", {15'd0, o_valid, o_pc, o_instr}, {15'd0, 1'b1, 16'h0004, 16'h0000});

    // Backpressure from start.
    cycle(0, 0, 0, 0, 16'h0, 1);
    cycle(1, 0, 0, 0, 16'h0, 0);
    repeat (4) cycle(0, 0, 0, 0, 16'h0, 0);
    check("bp_addr", 32'(o_imem_addr), 32'h0004);
    check("bp_head", {o_pc, o_instr}, {16'h0000, 16'h0040});
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("bp_resume1", 32'(o_pc), 32'h0002);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("bp_resume2", 32'(o_pc), 32'h0004);

    // Redirect with a full buffer, odd target.
    cycle(0, 0, 0, 0, 16'h0, 1);
    cycle(1, 0, 0, 0, 16'h0, 0);
    repeat (3) cycle(0, 0, 0, 0, 16'h0, 0);
    cycle(0, 0, 0, 1, 16'h0009, 0);
    check("redir_valid", 32'(o_valid), 32'd0);
    check("redir_addr", 32'(o_imem_addr), 32'h0008);
    cycle(0, 0, 0, 0, 16'h0, 0);
    check("redir_head", {15'd0, o_valid, o_pc, o_instr}, {15'd0, 1'b1, 16'h0008, 16'h006C});

    // Halt with two entries buffered, drain, then resume.
    cycle(0, 0, 0, 0, 16'h0, 0);
    cycle(0, 1, 0, 0, 16'h0, 0);
    check("halt_flag", 32'(o_halted), 32'd1);
    check("halt_addr", 32'(o_imem_addr), 32'h000C);
    repeat (2) cycle(0, 0, 0, 0, 16'h0, 0);
    check("halt_frozen", 32'(o_imem_addr), 32'h000C);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("drain1_valid", 32'(o_valid), 32'd1);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("drain_empty", 32'(o_valid), 32'd0);
    cycle(1, 0, 1, 0, 16'h0, 0);
    check("resume_addr", 32'(o_imem_addr), 32'h000C);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("resume_head", {15'd0, o_valid, o_pc}, {15'd0, 1'b1, 16'h000C});

    // PC wrap.
    cycle(0, 0, 1, 1, 16'hFFFE, 0);
    check("wrap_addr", 32'(o_imem_addr), 32'h0000FFFE);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("wrap_pc1", 32'(o_pc), 32'h0000FFFE);
    cycle(0, 0, 1, 0, 16'h0, 0);
    check("wrap_pc2", 32'(o_pc), 32'h00000000);

    // Reset overrides start mid-run with a full buffer.
    repeat (2) cycle(0, 0, 0, 0, 16'h0, 0);
    cycle(1, 0, 0, 0, 16'h0, 1);
    check("mrst_valid", 32'(o_valid), 32'd0);
    check("mrst_addr", 32'(o_imem_addr), 32'h0000);
    check("mrst_running", 32'(o_running), 32'd0);

    // Randomised traffic against the stream model.
    for (int n = 0; n < 3000; n++) begin
      logic st, hl, rd, rdr, rs;
      logic [15:0] rpc;
      rd  = ($urandom_range(0, 9) < 7);
      hl  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 7) == 0);
      rdr = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      rpc = 16'($urandom);
      if (rdr) st = 1'b0;
      cycle(st, hl, rd, rdr, rpc, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
